// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID register, debug-loaded instruction memory,
// stall/flush/HALT handling and a cycle counter. Optional single-step: IF_STEP_EN.
module if_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD  = 32'hFFFF_FFFF
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_burbuja,
  input  logic                  i_branch,
  input  logic [DATA_WIDTH-1:0] i_pcbranch,
  input  logic                  i_jump,
  input  logic [DATA_WIDTH-1:0] i_pcjump,
  input  logic                  i_load,
  input  logic [ADDR_WIDTH-1:0] i_load_addr,
  input  logic [DATA_WIDTH-1:0] i_load_data,
`ifdef IF_STEP_EN
  input  logic                  i_step,
`endif
  output logic [DATA_WIDTH-1:0] o_instruccion,
  output logic [DATA_WIDTH-1:0] o_currentpc,
  output logic [DATA_WIDTH-1:0] o_pc,
  output logic                  o_halt,
  output logic [DATA_WIDTH-1:0] o_cycles
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] fetch_word;
  logic                  advance;
  logic                  halted;

`ifdef IF_STEP_EN
  assign advance = i_step;
`else
  assign advance = 1'b1;
`endif

  assign pc_plus4   = pc + DATA_WIDTH'(4);
  assign fetch_word = mem[pc[ADDR_WIDTH+1:2]];

  // Memory has no reset so a program loaded while reset is held survives it.
  always_ff @(posedge i_clock) begin
    if (i_load) begin
      mem[i_load_addr] <= i_load_data;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      pc            <= '0;
      o_instruccion <= '0;
      o_currentpc   <= '0;
      halted        <= 1'b0;
      o_cycles      <= '0;
    end else if (advance) begin
      if (halted) begin
        o_instruccion <= '0;
      end else begin
        o_cycles <= o_cycles + 1'b1;
        if (!i_burbuja) begin
          if (i_jump) begin
            pc            <= i_pcjump;
            o_instruccion <= '0;
            o_currentpc   <= '0;
          end else if (i_branch) begin
            pc            <= i_pcbranch;
            o_instruccion <= '0;
            o_currentpc   <= '0;
          end else begin
            pc            <= pc_plus4;
            o_instruccion <= fetch_word;
            o_currentpc   <= pc_plus4;
            // Halt only when the HALT word is actually captured into IF/ID.
            if (fetch_word == HALT_WORD) begin
              halted <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign o_pc   = pc;
  assign o_halt = halted;

endmodule
